// File: rtl/eh2_lsu_amo_ctl.sv
// Atomic (AMO / LR.W / SC.W) sequencer: arbitrates thread requests, runs each one as a
// DCCM read-modify-write through an external combinational ALU, and tracks LR reservations.
module eh2_lsu_amo_ctl #(
  parameter  int NUM_THREADS = 2,
  parameter  int RSV_LSB     = 2,
  localparam int TW          = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic [NUM_THREADS-1:0]   req_valid,
  output logic [NUM_THREADS-1:0]   req_ready,
  input  logic [5*NUM_THREADS-1:0] req_op,
  input  logic [NUM_THREADS-1:0]   req_unsign,
  input  logic [32*NUM_THREADS-1:0] req_addr,
  input  logic [32*NUM_THREADS-1:0] req_wdata,
  input  logic [NUM_THREADS-1:0]   flush,
  output logic                     dccm_rd_en,
  output logic                     dccm_wr_en,
  output logic [31:0]              dccm_addr,
  output logic [31:0]              dccm_wr_data,
  input  logic                     dccm_gnt,
  input  logic                     dccm_rd_valid,
  input  logic [31:0]              dccm_rd_data,
  output logic                     amo_valid,
  output logic [4:0]               amo_op,
  output logic                     amo_unsign,
  output logic [31:0]              amo_mem_data,
  output logic [31:0]              amo_src_data,
  input  logic [31:0]              amo_result,
  input  logic                     snoop_valid,
  input  logic [31:0]              snoop_addr,
  output logic                     rsp_valid,
  output logic [TW-1:0]            rsp_tid,
  output logic [31:0]              rsp_data
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RDW, S_DRAIN, S_EXEC, S_WR, S_RSP} state_t;

  localparam logic [4:0]  OP_SWAP = 5'd1;
  localparam logic [4:0]  OP_LR   = 5'd2;
  localparam logic [4:0]  OP_SC   = 5'd3;
  localparam logic [31:0] GMASK   = ~((32'd1 << RSV_LSB) - 32'd1);

  // Unknown encodings execute as swap so the ALU only ever sees legal ops.
  function automatic logic [4:0] legalize(input logic [4:0] op);
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd12,
      5'd16, 5'd20, 5'd24, 5'd28: legalize = op;
      default:                    legalize = OP_SWAP;
    endcase
  endfunction

  state_t                 state_q, state_d;
  logic [TW-1:0]          rr_q, rr_d, tid_q, win;
  logic                   found, accept, sc_pass, tid_flush;
  logic [NUM_THREADS-1:0] elig;
  logic [4:0]             op_q, win_op;
  logic                   unsign_q, sc_fail_q;
  logic [31:0]            addr_q, src_q, old_q, wr_data_q;
  logic [31:0]            win_addr, win_wdata, win_gran, snoop_gran, addr_gran;
  logic [NUM_THREADS-1:0] rsv_vld_q, rsv_vld_d;
  logic [31:0]            rsv_gran_q [NUM_THREADS];
  logic [31:0]            rsv_gran_d [NUM_THREADS];

  // Round-robin search starting at the pointer; flushed threads are not eligible.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    found = 1'b0;
    win   = '0;
    elig  = req_valid & ~flush;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (!found && elig[(int'(rr_q) + i) % NUM_THREADS]) begin
        found = 1'b1;
        win   = TW'((int'(rr_q) + i) % NUM_THREADS);
      end
    end
  end

  assign accept     = (state_q == S_IDLE) && found;
  assign win_op     = legalize(req_op[int'(win)*5 +: 5]);
  assign win_addr   = req_addr[int'(win)*32 +: 32];
  assign win_wdata  = req_wdata[int'(win)*32 +: 32];
  assign win_gran   = win_addr & GMASK;
  assign snoop_gran = snoop_addr & GMASK;
  assign addr_gran  = addr_q & GMASK;
  assign tid_flush  = flush[tid_q];
  // A snoop hitting the granule in the SC's own accept cycle beats the reservation.
  assign sc_pass    = rsv_vld_q[win] && (rsv_gran_q[win] == win_gran) &&
                      !(snoop_valid && (snoop_gran == win_gran));
  assign rr_d       = !accept ? rr_q : (int'(win) == NUM_THREADS - 1) ? '0 : win + TW'(1);

  always_ff @(posedge clk or negedge rst_l) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!rst_l) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (win_op != OP_SC) ? S_RD : sc_pass ? S_WR : S_RSP;
      S_RD:    if (tid_flush)          state_d = dccm_gnt ? S_DRAIN : S_IDLE;
               else if (dccm_gnt)      state_d = S_RDW;
      S_RDW:   if (tid_flush)          state_d = dccm_rd_valid ? S_IDLE : S_DRAIN;
               else if (dccm_rd_valid) state_d = (op_q == OP_LR) ? S_RSP : S_EXEC;
      S_DRAIN: if (dccm_rd_valid)      state_d = S_IDLE;
      S_EXEC:  state_d = S_WR;
      S_WR:    if (dccm_gnt)           state_d = S_RSP;
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
    dccm_rd_en   = (state_q == S_RD);
    dccm_wr_en   = (state_q == S_WR);
    dccm_addr    = addr_q;
    dccm_wr_data = wr_data_q;
    amo_valid    = (state_q == S_EXEC);
    amo_op       = op_q;
    amo_unsign   = unsign_q;
    amo_mem_data = old_q;
    amo_src_data = src_q;
    rsp_valid    = (state_q == S_RSP);
    rsp_tid      = rsp_valid ? tid_q : '0;
    rsp_data     = !rsp_valid ? 32'd0 : (op_q == OP_SC) ? {31'd0, sc_fail_q} : old_q;
  end

  // Reservation bookkeeping: LR sets, SC consumes, foreign writes / snoops / flush clear.
  always_comb begin
    rsv_vld_d  = rsv_vld_q;
    rsv_gran_d = rsv_gran_q;
    if ((state_q == S_RDW) && dccm_rd_valid && (op_q == OP_LR) && !tid_flush &&
        !(snoop_valid && (snoop_gran == addr_gran))) begin
      rsv_vld_d[tid_q]  = 1'b1;
      rsv_gran_d[tid_q] = addr_gran;
    end
    if (accept && (win_op == OP_SC)) rsv_vld_d[win] = 1'b0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (snoop_valid && (rsv_gran_d[t] == snoop_gran)) rsv_vld_d[t] = 1'b0;
      if ((state_q == S_WR) && dccm_gnt && (t != int'(tid_q)) && (rsv_gran_d[t] == addr_gran))
        rsv_vld_d[t] = 1'b0;
      if (flush[t]) rsv_vld_d[t] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rr_q       <= '0;
      tid_q      <= '0;
      op_q       <= '0;
      unsign_q   <= 1'b0;
      sc_fail_q  <= 1'b0;
      addr_q     <= '0;
      src_q      <= '0;
      old_q      <= '0;
      wr_data_q  <= '0;
      rsv_vld_q  <= '0;
      // NOTE: the granule array is reset too, so no X can reach the reservation compares.
      rsv_gran_q <= '{default: '0};
    end else begin
      if (accept) begin
        op_q      <= win_op;
        unsign_q  <= req_unsign[win];
        addr_q    <= win_addr;
        src_q     <= win_wdata;
        wr_data_q <= win_wdata;
        tid_q     <= win;
        sc_fail_q <= !sc_pass;
      end
      if ((state_q == S_RDW) && dccm_rd_valid) old_q     <= dccm_rd_data;
      if (state_q == S_EXEC)                   wr_data_q <= amo_result;
      rr_q       <= rr_d;
      rsv_vld_q  <= rsv_vld_d;
      rsv_gran_q <= rsv_gran_d;
    end
  end

endmodule
